// File: rtl/pwm_generator.sv
// pwm_generator
//   Per-transducer PWM generator. On an UPDATE request, a sequential sweep
//   visits one channel per clock and turns DUTY/PHASE/CYCLE into rise/fall
//   edges. The edges go into shadow registers. Each channel copies its shadow
//   into its active edges at its own period boundary (TIME_CNT == CYCLE-1).
//   PWM_OUT is then a registered function of the active edges and TIME_CNT.
//
// Optional feature (macro PWM_OUTPUT_MASK_EN):
//   Adds OUTPUT_MASK[DEPTH]. The mask is ANDed into the output register, so it
//   takes effect immediately and does not add latency.
//
// Ports:
//   CLK          system clock
//   RST          asynchronous active-high reset
//   TIME_CNT[i]  per-channel time count, 0..CYCLE[i]-1
//   CYCLE[i]     per-channel period (>= 2)
//   DUTY[i]      high width in counts
//   PHASE[i]     pulse centre in counts (< CYCLE[i])
//   UPDATE       single-cycle sweep request
//   BUSY         sweep in progress (DEPTH+2 cycles per sweep)
//   DONE         single-cycle pulse in the last BUSY cycle of a sweep
//   OUTPUT_MASK  per-channel output enable (PWM_OUTPUT_MASK_EN only)
//   PWM_OUT      registered per-channel PWM output
module pwm_generator #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] TIME_CNT [DEPTH],
  input  logic [WIDTH-1:0] CYCLE    [DEPTH],
  input  logic [WIDTH-1:0] DUTY     [DEPTH],
  input  logic [WIDTH-1:0] PHASE    [DEPTH],
  input  logic             UPDATE,
`ifdef PWM_OUTPUT_MASK_EN
  input  logic [DEPTH-1:0] OUTPUT_MASK,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [DEPTH-1:0] PWM_OUT
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW   = WIDTH + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            issue;

  // ---------------------------------------------------------------------------
  // Sweep FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (UPDATE) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (UPDATE) pending_d = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StFlush;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFlush: begin
        // An UPDATE arriving here has missed this sweep's sampling, so it
        // triggers the follow-up sweep just as a pending request does.
        if (pending_q || UPDATE) begin
          state_d   = StRun;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    issue  = (state_q == StRun);
    done_d = (state_q == StFlush);
    // BUSY stays high through the DONE cycle. It also stays high across a
    // pending restart.
    busy_d = (state_d != StIdle) || done_d;
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

  // ---------------------------------------------------------------------------
  // Stage 1: edge arithmetic for the channel being issued
  // ---------------------------------------------------------------------------
  logic [EW-1:0] c_duty, c_phase, c_cycle, c_h, c_g;
  logic [EW-1:0] c_rise, c_fall_raw, c_fall;
  logic          c_full;
  logic          unused_edge_msb;

  always_comb begin
    c_duty     = {1'b0, DUTY[idx_q]};
    c_phase    = {1'b0, PHASE[idx_q]};
    c_cycle    = {1'b0, CYCLE[idx_q]};
    c_h        = c_duty >> 1;
    c_g        = (c_duty + 1'b1) >> 1;
    c_rise     = (c_phase >= c_h) ? (c_phase - c_h) : (c_phase + c_cycle - c_h);
    c_fall_raw = c_phase + c_g;
    c_fall     = (c_fall_raw >= c_cycle) ? (c_fall_raw - c_cycle) : c_fall_raw;
    c_full     = (c_duty >= c_cycle);
  end

  // Both results are below CYCLE, so their top bit is always zero.
  assign unused_edge_msb = c_rise[WIDTH] ^ c_fall[WIDTH];

  logic             s_valid_q;
  logic [IdxW-1:0]  s_idx_q;
  logic [WIDTH-1:0] s_rise_q, s_fall_q;
  logic             s_full_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_valid_q <= 1'b0;
      s_idx_q   <= '0;
      s_rise_q  <= '0;
      s_fall_q  <= '0;
      s_full_q  <= 1'b0;
    end else begin
      s_valid_q <= issue;
      s_idx_q   <= idx_q;
      s_rise_q  <= c_rise[WIDTH-1:0];
      s_fall_q  <= c_fall[WIDTH-1:0];
      s_full_q  <= c_full;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shadow write, load-valid tracking, period-boundary load
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sh_rise_q  [DEPTH];
  logic [WIDTH-1:0] sh_fall_q  [DEPTH];
  logic [DEPTH-1:0] sh_full_q;
  logic [WIDTH-1:0] act_rise_q [DEPTH];
  logic [WIDTH-1:0] act_fall_q [DEPTH];
  logic [DEPTH-1:0] act_full_q;
  logic [DEPTH-1:0] load_valid_q;
  logic [DEPTH-1:0] load;

  always_comb begin
    load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = load_valid_q[i] && (TIME_CNT[i] == (CYCLE[i] - WIDTH'(1)));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        sh_rise_q[i] <= '0;
        sh_fall_q[i] <= '0;
      end
      sh_full_q    <= '0;
      load_valid_q <= '0;
    end else begin
      load_valid_q <= load_valid_q & ~load;
      // A fresh write wins over a same-cycle load, so the newest value still
      // loads at the following boundary.
      if (s_valid_q) begin
        sh_rise_q[s_idx_q]    <= s_rise_q;
        sh_fall_q[s_idx_q]    <= s_fall_q;
        sh_full_q[s_idx_q]    <= s_full_q;
        load_valid_q[s_idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_rise_q[i] <= '0;
        act_fall_q[i] <= '0;
      end
      act_full_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          act_rise_q[i] <= sh_rise_q[i];
          act_fall_q[i] <= sh_fall_q[i];
          act_full_q[i] <= sh_full_q[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output compare and register
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] pwm_d, pwm_q;

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (act_full_q[i]) begin
        pwm_d[i] = 1'b1;
      end else if (act_rise_q[i] < act_fall_q[i]) begin
        pwm_d[i] = (TIME_CNT[i] >= act_rise_q[i]) && (TIME_CNT[i] < act_fall_q[i]);
      end else if (act_rise_q[i] > act_fall_q[i]) begin
        pwm_d[i] = (TIME_CNT[i] < act_fall_q[i]) || (TIME_CNT[i] >= act_rise_q[i]);
      end else begin
        pwm_d[i] = 1'b0;
      end
    end
`ifdef PWM_OUTPUT_MASK_EN
    pwm_d = pwm_d & OUTPUT_MASK;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Testbench for pwm_generator. Each channel gets its own time counter. The
// bench steps through a table of hand-computed vectors. It then runs directed
// sequences for update timing, coalesced updates, extremes and mid-sweep reset.
module tb_pwm_generator;

  localparam int unsigned W = 13;
  localparam int unsigned D = 249;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] time_cnt [D];
  logic [W-1:0] cycle    [D];
  logic [W-1:0] duty     [D];
  logic [W-1:0] phase    [D];
  logic         update;
  logic         busy;
  logic         done;
  logic [D-1:0] pwm_out;
  logic [W-1:0] last_t   [D];  // TIME_CNT seen by the DUT at the last posedge

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_generator #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK        (clk),
    .RST        (rst),
    .TIME_CNT   (time_cnt),
    .CYCLE      (cycle),
    .DUTY       (duty),
    .PHASE      (phase),
    .UPDATE     (update),
`ifdef PWM_OUTPUT_MASK_EN
    .OUTPUT_MASK({D{1'b1}}),
`endif
    .BUSY       (busy),
    .DONE       (done),
    .PWM_OUT    (pwm_out)
  );

  // Time-count source: each channel counts 0..cycle-1, stepping 1 ns after each edge.
  initial begin
    for (int i = 0; i < D; i++) begin
      time_cnt[i] = '0;
      last_t[i]   = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < D; i++) begin
        last_t[i] = time_cnt[i];
        if (int'(time_cnt[i]) + 1 >= int'(cycle[i])) time_cnt[i] = '0;
        else time_cnt[i] = time_cnt[i] + W'(1);
      end
    end
  end

  // Watchdog.
  initial begin
    #990000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int cyc;
    int duty;
    int phase;
    int rise;
    int fall;
    int full;
    int highs;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int actual, input int required);
    n_vec++;
    if (actual != required) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, actual, required);
    end
  endtask

  function automatic int exp_pwm(input int rise, input int fall, input int full, input int t);
    if (full != 0) return 1;
    if (rise < fall) return ((t >= rise) && (t < fall)) ? 1 : 0;
    if (rise > fall) return ((t < fall) || (t >= rise)) ? 1 : 0;
    return 0;
  endfunction

  task automatic set_all(input int c, input int dt, input int ph);
    for (int i = 0; i < D; i++) begin
      cycle[i] = W'(c);
      duty[i]  = W'(dt);
      phase[i] = W'(ph);
    end
  endtask

  // Pulse UPDATE at a negedge, then wait (bounded) for DONE.
  task automatic sweep(input string name);
    bit found = 1'b0;
    update = 1'b1;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      update = 1'b0;
      if (done) found = 1'b1;
    end
    check({name, "_done_seen"}, int'(found), 1);
  endtask

  // Skip one negedge, then stop on the negedge whose edge saw t == c-1.
  task automatic wait_wrap(input string name, input int c);
    bit found = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 9000 && !found; k++) begin
      @(negedge clk);
      if (int'(last_t[0]) == c - 1) found = 1'b1;
    end
    check({name, "_wrap_seen"}, int'(found), 1);
  endtask

  // Check one full period on channels 0 and 100 against expected edges.
  task automatic check_period(input string name, input vec_t v);
    int bad   = 0;
    int highs = 0;
    for (int k = 0; k < v.cyc; k++) begin
      @(negedge clk);
      if (int'(pwm_out[0]) != exp_pwm(v.rise, v.fall, v.full, int'(last_t[0]))) bad++;
      if (int'(pwm_out[100]) != exp_pwm(v.rise, v.fall, v.full, int'(last_t[100]))) bad++;
      highs += int'(pwm_out[0]);
    end
    check({name, "_wave_err"}, bad, 0);
    check({name, "_highs"}, highs, v.highs);
  endtask

  initial begin
    int busy_cnt, done_cnt, old_bad, new_bad, new_high, seg, bad0, bad100, bad248;
    bit seen0, seen248, found;

    //          cyc   duty  phase rise  fall full highs
    vecs[0] = '{100,  31,   95,   80,   11,  0,   31};
    vecs[1] = '{100,  7,    50,   47,   54,  0,   7};
    vecs[2] = '{2,    1,    1,    1,    0,   0,   1};
    vecs[3] = '{100,  0,    10,   10,   10,  0,   0};
    vecs[4] = '{100,  150,  3,    28,   78,  1,   100};
    vecs[5] = '{100,  100,  99,   49,   49,  1,   100};
    vecs[6] = '{4096, 1,    0,    0,    1,   0,   1};
    vecs[7] = '{4096, 1000, 0,    3596, 500, 0,   1000};
    vecs[8] = '{4096, 2048, 2048, 1024, 3072, 0,  2048};

    update = 1'b0;
    rst    = 1'b1;
    set_all(4096, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pwm", $countones(pwm_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      set_all(vecs[v].cyc, vecs[v].duty, vecs[v].phase);
      sweep(nm);
      wait_wrap(nm, vecs[v].cyc);
      check_period(nm, vecs[v]);
    end

    // Update mid-period at t=1500: old waveform runs to 4095, then new edges.
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge clk);
      if (int'(time_cnt[0]) == 1500) found = 1'b1;
    end
    check("tmg_t1500_seen", int'(found), 1);
    set_all(4096, 1000, 0);
    update   = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    old_bad  = 0;
    new_bad  = 0;
    new_high = 0;
    seg      = 0;
    for (int k = 0; k < 6692; k++) begin
      @(negedge clk);
      update = 1'b0;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (seg == 0) begin
        if (int'(pwm_out[0]) != exp_pwm(1024, 3072, 0, int'(last_t[0]))) old_bad++;
        if (int'(last_t[0]) == 4095) seg = 1;
      end else begin
        if (int'(pwm_out[0]) != exp_pwm(3596, 500, 0, int'(last_t[0]))) new_bad++;
        new_high += int'(pwm_out[0]);
      end
    end
    check("tmg_busy_cycles", busy_cnt, 251);
    check("tmg_done_pulses", done_cnt, 1);
    check("tmg_old_wave_err", old_bad, 0);
    check("tmg_new_wave_err", new_bad, 0);
    check("tmg_new_highs", new_high, 1000);

    // Two UPDATEs during BUSY coalesce into one extra sweep; its values win.
    set_all(100, 7, 50);
    update   = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      update = (k == 20 || k == 40) ? 1'b1 : 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) set_all(100, 31, 95);
      end
    end
    check("dbl_done_pulses", done_cnt, 2);
    check("dbl_busy_after", int'(busy), 0);
    wait_wrap("dbl", 100);
    check_period("dbl", vecs[0]);

    // Extremes: DUTY=0 stays low; DUTY>CYCLE stays high; last channel with
    // CYCLE=4097, DUTY=4097 stays high.
    set_all(4096, 0, 10);
    duty[100]  = W'(5000);
    phase[100] = W'(7);
    cycle[D-1] = W'(4097);
    duty[D-1]  = W'(4097);
    phase[D-1] = W'(5);
    sweep("ext");
    @(negedge clk);
    seen0   = 1'b0;
    seen248 = 1'b0;
    for (int k = 0; k < 9000 && !(seen0 && seen248); k++) begin
      @(negedge clk);
      if (int'(last_t[0]) == 4095) seen0 = 1'b1;
      if (int'(last_t[D-1]) == 4096) seen248 = 1'b1;
    end
    check("ext_wraps_seen", int'(seen0 && seen248), 1);
    bad0   = 0;
    bad100 = 0;
    bad248 = 0;
    for (int k = 0; k < 4200; k++) begin
      @(negedge clk);
      bad0   += int'(pwm_out[0]);
      bad100 += int'(!pwm_out[100]);
      bad248 += int'(!pwm_out[D-1]);
    end
    check("ext_duty0_highs", bad0, 0);
    check("ext_full_lows", bad100, 0);
    check("ext_last_full_lows", bad248, 0);

    // Reset at sweep index 100 clears everything; nothing loads afterwards.
    set_all(4096, 2048, 2048);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_busy_async", int'(busy), 0);
    check("rst_done_async", int'(done), 0);
    check("rst_pwm_async", $countones(pwm_out), 0);
    @(negedge clk);
    rst  = 1'b0;
    bad0 = 0;
    for (int k = 0; k < 4300; k++) begin
      @(negedge clk);
      bad0 += $countones(pwm_out) + int'(busy) + int'(done);
    end
    check("rst_quiet_after", bad0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
